// File: rtl/pc_update_pkg.sv
// Shared pipeline definitions for the fetch-address generator: FSM states,
// default PC width, reset address and flush-length bounds.
package pc_update_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2
  } pc_state_e;

  localparam int          PC_WIDTH             = 32;
  localparam logic [31:0] PC_RESET_VALUE       = 32'h0000_0000;
  localparam int          FLUSH_CYCLES_DEFAULT = 2;
  localparam int          FLUSH_CYCLES_MAX     = 7;
  localparam int          FLUSH_CNT_W          = 3;

endpackage

// File: rtl/pc_update.sv
// Program counter with redirect handling: sequential fetch, taken-branch
// redirect (deferred while stalled) and a counted IF/ID flush window.
module pc_update
  import pc_update_pkg::*;
#(
  parameter int               WIDTH        = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC     = WIDTH'(PC_RESET_VALUE),
  parameter int               FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT  // 1..FLUSH_CYCLES_MAX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             take,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             flush,
  output logic             misalign,
  output pc_state_e        dbg_state
);

  localparam logic [FLUSH_CNT_W-1:0] CNT_INIT = FLUSH_CNT_W'(FLUSH_CYCLES);
  localparam logic [FLUSH_CNT_W-1:0] CNT_ONE  = FLUSH_CNT_W'(1);
  localparam logic [WIDTH-1:0]       PC_STEP  = WIDTH'(4);

  // Handshake: take/target form a single-cycle request that is consumed on
  // the rising edge where it is sampled in RUN; there is no ready back to
  // the requester, so a redirect arriving in PEND or FLUSH is simply dropped.

  pc_state_e              state, state_n;
  logic [FLUSH_CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0]       tgt_q, tgt_n;
  logic [WIDTH-1:0]       pc_n;
  logic                   mis_n;

  assign pc_plus4  = pc + PC_STEP;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      pc       <= RESET_PC;
      cnt      <= '0;
      tgt_q    <= '0;
      flush    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      cnt      <= cnt_n;
      tgt_q    <= tgt_n;
      flush    <= (state_n == FLUSH);
      misalign <= mis_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    cnt_n   = cnt;
    tgt_n   = tgt_q;
    mis_n   = 1'b0;
    case (state)
      RUN: begin
        if (take && stall) begin
          tgt_n   = target;
          state_n = PEND;
        end else if (take) begin
          pc_n    = {target[WIDTH-1:2], 2'b00};
          mis_n   = |target[1:0];
          cnt_n   = CNT_INIT;
          state_n = FLUSH;
        end else if (!stall) begin
          pc_n = pc_plus4;
        end
      end
      PEND: begin
        // The first latched redirect wins; later takes are not looked at.
        if (!stall) begin
          pc_n    = {tgt_q[WIDTH-1:2], 2'b00};
          mis_n   = |tgt_q[1:0];
          tgt_n   = '0;
          cnt_n   = CNT_INIT;
          state_n = FLUSH;
        end
      end
      FLUSH: begin
        if (!stall) begin
          pc_n  = pc_plus4;
          cnt_n = cnt - CNT_ONE;
          if (cnt == CNT_ONE) state_n = RUN;
        end
      end
      default: begin
        state_n = RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_update.sv
// Bench for pc_update: directed vector table, hand-written stall/reset
// sequences and a randomized run against a behavioural fetch model.
module tb_pc_update;
  import pc_update_pkg::*;

  localparam int W  = 32;
  localparam int FC = 2;

  logic          clk;
  logic          reset;
  logic          stall;
  logic          take;
  logic [W-1:0]  target;
  logic [W-1:0]  pc;
  logic [W-1:0]  pc_plus4;
  logic          flush;
  logic          misalign;
  pc_state_e     dbg_state;

  int checks = 0;
  int errors = 0;

  pc_update #(.WIDTH(W), .RESET_PC(32'h0), .FLUSH_CYCLES(FC)) dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .take     (take),
    .target   (target),
    .pc       (pc),
    .pc_plus4 (pc_plus4),
    .flush    (flush),
    .misalign (misalign),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model: fetch address, queue of deferred redirects,
  // and the number of advancing cycles the flush window still lasts
  logic [W-1:0] m_pc;
  logic [W-1:0] pend_q[$];
  int           flush_left;
  logic         m_mis;
  logic [W-1:0] exp_q[$];

  function automatic void model_reset();
    m_pc       = 32'h0;
    pend_q.delete();
    flush_left = 0;
    m_mis      = 1'b0;
  endfunction

  function automatic void model_apply(input logic [W-1:0] t);
    m_pc       = t & 32'hFFFF_FFFC;
    m_mis      = (t % 4) != 0;
    flush_left = FC;
  endfunction

  function automatic void model_step(input logic s, input logic tk, input logic [W-1:0] t);
    m_mis = 1'b0;
    if (flush_left > 0) begin
      if (!s) begin
        m_pc       = m_pc + 32'd4;
        flush_left = flush_left - 1;
      end
    end else if (pend_q.size() > 0) begin
      if (!s) model_apply(pend_q.pop_front());
    end else if (tk) begin
      if (s) pend_q.push_back(t);
      else   model_apply(t);
    end else if (!s) begin
      m_pc = m_pc + 32'd4;
    end
    exp_q.push_back(m_pc);
  endfunction

  // scoreboard
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    chk({tag, ".pc"},       pc,              e);
    chk({tag, ".pc_plus4"}, pc_plus4,        e + 32'd4);
    chk({tag, ".flush"},    {31'b0, flush},  {31'b0, flush_left > 0});
    chk({tag, ".misalign"}, {31'b0, misalign}, {31'b0, m_mis});
  endtask

  // driver: apply inputs for one edge, advance the model, sample at negedge
  task automatic drive(input logic s, input logic tk, input logic [W-1:0] t, input string tag);
    stall  = s;
    take   = tk;
    target = t;
    @(posedge clk);
    model_step(s, tk, t);
    @(negedge clk);
    chk_model(tag);
  endtask

  task automatic expect_now(input string tag, input logic [W-1:0] epc, input logic ef, input logic em);
    chk({tag, ".pc"},       pc,                epc);
    chk({tag, ".flush"},    {31'b0, flush},    {31'b0, ef});
    chk({tag, ".misalign"}, {31'b0, misalign}, {31'b0, em});
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    model_reset();
    expect_now(tag, 32'h0, 1'b0, 1'b0);
    chk({tag, ".state"}, 32'(dbg_state), 32'(RUN));
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic         s;
    logic         tk;
    logic [W-1:0] t;
    logic [W-1:0] epc;
    logic         ef;
    logic         em;
  } vec_t;

  vec_t vecs[$];

  initial begin
    reset  = 1'b0;
    stall  = 1'b0;
    take   = 1'b0;
    target = '0;
    model_reset();
    repeat (2) @(negedge clk);
    expect_now("reset", 32'h0, 1'b0, 1'b0);
    chk("reset.pc_plus4", pc_plus4, 32'h4);
    chk("reset.state", 32'(dbg_state), 32'(RUN));
    reset = 1'b1;

    // sequential fetch, aligned redirect, misaligned redirect
    vecs = '{
      '{1'b0, 1'b0, 32'h0,   32'h4,   1'b0, 1'b0},
      '{1'b0, 1'b0, 32'h0,   32'h8,   1'b0, 1'b0},
      '{1'b0, 1'b0, 32'h0,   32'hC,   1'b0, 1'b0},
      '{1'b0, 1'b0, 32'h0,   32'h10,  1'b0, 1'b0},
      '{1'b0, 1'b1, 32'h200, 32'h200, 1'b1, 1'b0},
      '{1'b0, 1'b0, 32'h0,   32'h204, 1'b1, 1'b0},
      '{1'b0, 1'b0, 32'h0,   32'h208, 1'b0, 1'b0},
      '{1'b0, 1'b1, 32'h103, 32'h100, 1'b1, 1'b1},
      '{1'b0, 1'b0, 32'h0,   32'h104, 1'b1, 1'b0},
      '{1'b0, 1'b0, 32'h0,   32'h108, 1'b0, 1'b0}
    };
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].s, vecs[i].tk, vecs[i].t, $sformatf("vec%0d", i));
      expect_now($sformatf("vec%0d.tbl", i), vecs[i].epc, vecs[i].ef, vecs[i].em);
    end

    // redirect during stall: first target wins, pc holds 3 cycles
    drive(1'b1, 1'b1, 32'h400, "pend0"); expect_now("pend0.c", 32'h108, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 32'h800, "pend1"); expect_now("pend1.c", 32'h108, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 32'h0,   "pend2"); expect_now("pend2.c", 32'h108, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 32'h800, "pend3"); expect_now("pend3.c", 32'h400, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'h0,   "pend4"); expect_now("pend4.c", 32'h404, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'h0,   "pend5"); expect_now("pend5.c", 32'h408, 1'b0, 1'b0);

    // stall inside the flush window freezes pc and the flush count
    drive(1'b0, 1'b1, 32'h500, "fst0"); expect_now("fst0.c", 32'h500, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 32'h0,   "fst1"); expect_now("fst1.c", 32'h500, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 32'h900, "fst2"); expect_now("fst2.c", 32'h500, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 32'h900, "fst3"); expect_now("fst3.c", 32'h504, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'h0,   "fst4"); expect_now("fst4.c", 32'h508, 1'b0, 1'b0);

    // wrap at the top of the address space
    drive(1'b0, 1'b1, 32'hFFFF_FFF8, "wrap0"); expect_now("wrap0.c", 32'hFFFF_FFF8, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'h0, "wrap1"); expect_now("wrap1.c", 32'hFFFF_FFFC, 1'b1, 1'b0);
    chk("wrap1.pc_plus4", pc_plus4, 32'h0);
    drive(1'b0, 1'b0, 32'h0, "wrap2"); expect_now("wrap2.c", 32'h0, 1'b0, 1'b0);

    // asynchronous reset mid-flush and mid-pend
    drive(1'b0, 1'b1, 32'h300, "rflush"); expect_now("rflush.c", 32'h300, 1'b1, 1'b0);
    async_reset("rst_flush");
    drive(1'b0, 1'b0, 32'h0, "after_rf"); expect_now("after_rf.c", 32'h4, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 32'h600, "rpend"); expect_now("rpend.c", 32'h4, 1'b0, 1'b0);
    async_reset("rst_pend");
    drive(1'b0, 1'b0, 32'h0, "after_rp"); expect_now("after_rp.c", 32'h4, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, "after_rp2"); expect_now("after_rp2.c", 32'h8, 1'b0, 1'b0);

    // randomized run against the model
    for (int n = 0; n < 2000; n++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom(), "rand");
      if ($urandom_range(0, 399) == 0) async_reset("rand_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_update.md
PC_UPDATE -- requirements
Module: pc_update

Interface
REQ-001 The parameter list SHALL be: WIDTH, default 32, PC/target width.
REQ-002 The parameter list SHALL include: RESET_PC, default 0x00000000, PC value loaded on reset.
REQ-003 The parameter list SHALL include: FLUSH_CYCLES, default 2, number of advancing cycles for which flush stays asserted after a redirect; legal range 1..7.
REQ-004 The module SHALL have port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-006 The module SHALL have port: stall  in  1  hazard stall; 1 means the PC holds and the flush count is frozen.
REQ-007 The module SHALL have port: take  in  1  redirect request from branch_judge (branch taken or jump).
REQ-008 The module SHALL have port: target  in  WIDTH  redirect address, valid when take=1.
REQ-009 The module SHALL have port: pc  out  WIDTH  current fetch address, registered.
REQ-010 The module SHALL have port: pc_plus4  out  WIDTH  pc+4, combinational, modulo 2^WIDTH.
REQ-011 The module SHALL have port: flush  out  1  squash of the IF/ID contents, registered.
REQ-012 The module SHALL have port: misalign  out  1  one-cycle registered pulse when an applied target has target[1:0]!=0.

Function
REQ-013 The FSM SHALL have exactly three states: RUN, PEND (redirect latched during stall) and FLUSH.
REQ-014 In RUN with take=0 and stall=0, pc SHALL update to pc+4, wrapping 0xFFFFFFFC->0x00000000.
REQ-015 In RUN with stall=1 and take=0, pc SHALL hold.
REQ-016 In RUN with take=1 and stall=0, pc SHALL load {target[WIDTH-1:2],2'b00}, the counter SHALL load FLUSH_CYCLES, and the state SHALL go to FLUSH.
REQ-017 In RUN with take=1 and stall=1, target SHALL be latched into an internal register, pc SHALL hold, and the state SHALL go to PEND.
REQ-018 In PEND, pc SHALL hold while stall=1; take SHALL be ignored (the oldest redirect wins).
REQ-019 In PEND, when stall=0, pc SHALL load the latched target (low 2 bits cleared), the counter SHALL load FLUSH_CYCLES, and the state SHALL go to FLUSH.
REQ-020 flush SHALL be 1 exactly when the state is FLUSH; it SHALL be 0 in RUN and PEND.
REQ-021 In FLUSH, take SHALL be ignored because shadow instructions are squashed.
REQ-022 In FLUSH with stall=0, pc SHALL update to pc+4 and the counter SHALL decrement; when the counter reaches 0 the state SHALL return to RUN.
REQ-023 In FLUSH with stall=1, both pc and the counter SHALL hold.
REQ-024 misalign SHALL pulse for one cycle, coincident with the pc load, when the applied target has bits [1:0]!=0; it SHALL be 0 otherwise.
REQ-025 A redirect SHALL take 1 cycle from take sampled high (with stall=0) to the new pc being visible.

Reset
REQ-026 When reset=0, the block SHALL immediately set pc=RESET_PC, flush=0, misalign=0, state=RUN, counter=0 and latched target=0, independent of clk.
REQ-027 When reset is asserted during PEND or FLUSH, the pending redirect SHALL be discarded.
REQ-028 On the first rising edge after reset deasserts, normal RUN behaviour SHALL apply.

Structure
REQ-029 A shared pipeline package SHALL hold the state enum (RUN/PEND/FLUSH), the WIDTH default, RESET_PC, and the FLUSH_CYCLES default with its limit.
REQ-030 pc_update SHALL be a single module with no sub-modules; the counter and incrementer SHALL be inline.

Verification
REQ-031 Scenario: release reset, stall=0, take=0 for 4 cycles -> pc = 0x0, 0x4, 0x8, 0xC, 0x10; flush=0 throughout.
REQ-032 Scenario: at pc=0x10, take=1 with target=0x200 for one cycle -> next pc=0x200; flush=1 for 2 cycles while pc steps to 0x204 and 0x208; then flush=0.
REQ-033 Scenario: stall=1 and take=1 with target=0x400; then take=1 with target=0x800 while still stalled; stall released after 3 cycles -> pc held 3 cycles, then pc=0x400 (0x800 ignored), then flush=1 for 2 cycles.
REQ-034 Scenario: during FLUSH, stall=1 for 2 cycles -> pc and flush frozen; flush still totals 2 advancing cycles.
REQ-035 Scenario: take with target=0x103 -> pc=0x100 and misalign=1 for exactly that one cycle.
REQ-036 Scenarios: (a) pc=0xFFFFFFFC with no take -> pc=0x0 next cycle; (b) reset asserted mid-FLUSH -> pc=RESET_PC and flush=0 immediately, without waiting for clk.
